room_occupancy_tracker: RTL and testbench
=========================================

Name: room_occupancy_tracker

Overview:
- Sensor front-end that produces the per-room occupancy vector consumed by the room lighting controller.
- Each room has one door-entry sensor and one door-exit sensor. Both are raw, asynchronous, bouncy levels.
- Per room, the block synchronises and debounces both sensors, turns each debounced rising edge into one event, and keeps a saturating occupant count.
- Outputs: occupied flags (rooms), building total, sticky error flags and a selectable per-room count readback.

Parameters:
- NROOMS, 8: number of rooms/sensor pairs.
- CNT_W, 4: occupant counter width per room; max count 2^CNT_W-1 = 15.
- DEB_CYC, 3: consecutive stable synchronised cycles required to accept a level change; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- enter_raw  input  NROOMS  raw entry-sensor level per room (async).
- exit_raw  input  NROOMS  raw exit-sensor level per room (async).
- clr_err  input  1  synchronous clear of ovf/udf flags.
- sel  input  3  room index for readback (width = clog2(NROOMS)).
- rooms  output  NROOMS  bit i = 1 when room i count != 0.
- occ_total  output  CNT_W+3  sum of all room counts.
- occ_sel  output  CNT_W  count of room sel.
- ovf  output  NROOMS  sticky: entry event while count saturated at max.
- udf  output  NROOMS  sticky: exit event while count at 0.

Behaviour:
- Reset (async, rst=1): clears all sync flops, debounce counters, accepted levels, occupant counters, ovf and udf.
  - rooms=0, occ_total=0, occ_sel=0, ovf=0, udf=0.
  - Reset mid-operation discards all in-flight debounce state and counts immediately, with no clock needed.
- Synchroniser: each raw bit passes through 2 flops (s1, s2). The accepted level resets to 0.
- Debouncer, per bit:
  - If s2 != accepted: dcnt increments.
  - If s2 == accepted: dcnt = 0.
  - At the edge where dcnt would reach DEB_CYC, accepted flips and dcnt = 0.
  - Any return to the accepted level before then cancels the change. A glitch lasting fewer than DEB_CYC s2-cycles produces no event.
- Event: evt = accepted & ~accepted_d (accepted_d is a 1-cycle delay). This is a one-cycle pulse. Falling edges produce no event.
- Counter update, per room, registered:
  - enter_evt & ~exit_evt: count+1. If count == max, hold and set ovf[i].
  - exit_evt & ~enter_evt: count-1. If count == 0, hold and set udf[i].
  - Both events in the same cycle: count unchanged, no flag.
- Latency: raw level first sampled at edge 1; s2 valid at edge 2; accepted flips at edge 2+DEB_CYC; count updates at edge 3+DEB_CYC (edge 6 at default).
- rooms, occ_total, occ_sel are combinational decodes of the registered counts, so they change in the same cycle as the counts.
  - occ_total width CNT_W+3 holds 8*15 = 120 without wrap.
  - sel >= NROOMS (only when NROOMS is not a power of 2): occ_sel = 0.
- clr_err=1 clears all ovf/udf at the next edge. If a new error condition occurs in that same cycle, the flag is set (set wins over clear).
- Rooms are fully independent. Simultaneous events in different rooms all update in the same cycle.

Test Plan:
- Reset check: assert rst with enter_raw=8'hFF already debounced and counting, without a clock edge → rooms=0, occ_total=0, ovf=udf=0 immediately; after release, count resumes from 0 only on a new rising edge.
- Single entry: enter_raw[2] held 1 for 10 cycles from edge 1, default params → rooms=8'h04 first at edge 6, occ_total=1; sel=2 gives occ_sel=1. Exactly one increment.
- Debounce reject: enter_raw[0] high for 2 cycles, then low → no event, rooms=0. Bounce 1,0,1 then steady high → exactly one event.
- Enter/exit sequence: 3 entries then 1 exit on room 5 → occ_sel(sel=5)=2, occ_total=2, rooms[5]=1. Two more exits → count 0, rooms[5]=0. A further exit → udf[5]=1, count stays 0.
- Saturation: 16 entries on room 7 → count 15, ovf[7]=1. clr_err pulse → ovf=0. Another entry in the same cycle as clr_err → ovf[7] stays 1.
- Simultaneous events: enter and exit events coincide in room 1 → count unchanged, no flags. Enter events in all 8 rooms in one cycle → rooms=8'hFF, occ_total=8.

Source files
------------

// File: rtl/room_occupancy_tracker_if.sv
// Sensor-side bundle of the room occupancy tracker: raw door sensor levels and
// control in, occupancy flags, totals and error flags out.
interface room_occupancy_tracker_if #(
  parameter int NROOMS = 8,
  parameter int CNT_W  = 4,
  parameter int SEL_W  = 3
);
  logic [NROOMS-1:0]  enter_raw;
  logic [NROOMS-1:0]  exit_raw;
  logic               clr_err;
  logic [SEL_W-1:0]   sel;
  logic [NROOMS-1:0]  rooms;
  logic [CNT_W+2:0]   occ_total;
  logic [CNT_W-1:0]   occ_sel;
  logic [NROOMS-1:0]  ovf;
  logic [NROOMS-1:0]  udf;

  modport master (
    output enter_raw, exit_raw, clr_err, sel,
    input  rooms, occ_total, occ_sel, ovf, udf
  );

  modport slave (
    input  enter_raw, exit_raw, clr_err, sel,
    output rooms, occ_total, occ_sel, ovf, udf
  );
endinterface

// File: rtl/room_occupancy_tracker.sv
// Per-room occupancy counting from bouncy async door sensors: 2-flop sync,
// debounce, rising-edge event, saturating count with sticky ovf/udf flags.
module room_occupancy_tracker #(
  parameter int NROOMS  = 8,
  parameter int CNT_W   = 4,
  parameter int DEB_CYC = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  room_occupancy_tracker_if.slave  bus
);
  localparam int NB    = 2 * NROOMS;
  localparam int DW    = 4;
  localparam int TOT_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Entry sensors occupy the low half, exit sensors the high half.
  logic [NB-1:0]     raw, s1_q, s2_q, acc_q, acc_d, acc_dly_q, evt;
  logic [DW-1:0]     dcnt_q [NB];
  logic [DW-1:0]     dcnt_d [NB];
  logic [CNT_W-1:0]  cnt_q [NROOMS];
  logic [CNT_W-1:0]  cnt_d [NROOMS];
  logic [NROOMS-1:0] ovf_q, ovf_d, udf_q, udf_d, ent_evt, ext_evt;

  assign raw     = {bus.exit_raw, bus.enter_raw};
  assign evt     = acc_q & ~acc_dly_q;
  assign ent_evt = evt[NROOMS-1:0];
  assign ext_evt = evt[NB-1:NROOMS];

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      acc_d[b]  = acc_q[b];
      dcnt_d[b] = '0;
      if (s2_q[b] != acc_q[b]) begin
        if (dcnt_q[b] == DW'(DEB_CYC - 1)) acc_d[b] = ~acc_q[b];
        else                               dcnt_d[b] = dcnt_q[b] + DW'(1);
      end
    end
  end

  // Error flags: clear first, then any new error in the same cycle sets again.
  always_comb begin
    ovf_d = bus.clr_err ? '0 : ovf_q;
    udf_d = bus.clr_err ? '0 : udf_q;
    for (int i = 0; i < NROOMS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ent_evt[i] && !ext_evt[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (ext_evt[i] && !ent_evt[i]) begin
        if (cnt_q[i] == '0) udf_d[i] = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      acc_q     <= '0;
      acc_dly_q <= '0;
      ovf_q     <= '0;
      udf_q     <= '0;
      for (int b = 0; b < NB; b++)     dcnt_q[b] <= '0;
      for (int i = 0; i < NROOMS; i++) cnt_q[i]  <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      acc_q     <= acc_d;
      acc_dly_q <= acc_q;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      for (int b = 0; b < NB; b++)     dcnt_q[b] <= dcnt_d[b];
      for (int i = 0; i < NROOMS; i++) cnt_q[i]  <= cnt_d[i];
    end
  end

  always_comb begin
    bus.occ_total = '0;
    bus.occ_sel   = '0;
    for (int i = 0; i < NROOMS; i++) begin
      bus.rooms[i]  = (cnt_q[i] != '0);
      bus.occ_total = bus.occ_total + TOT_W'(cnt_q[i]);
    end
    if (32'(bus.sel) < NROOMS) bus.occ_sel = cnt_q[bus.sel];
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
endmodule

// File: tb/tb_room_occupancy_tracker.sv
// Directed bench for room_occupancy_tracker with hand-computed expectations.
module tb_room_occupancy_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  room_occupancy_tracker_if #(.NROOMS(8), .CNT_W(4), .SEL_W(3)) bus ();

  room_occupancy_tracker #(.NROOMS(8), .CNT_W(4), .DEB_CYC(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One debounced event on every set bit: high long enough to be accepted and
  // counted, then low long enough for the accepted level to fall again.
  task automatic ev(input logic [7:0] en, input logic [7:0] ex);
    bus.enter_raw = en;
    bus.exit_raw  = ex;
    tick(6);
    bus.enter_raw = '0;
    bus.exit_raw  = '0;
    tick(6);
  endtask

  task automatic do_reset();
    bus.enter_raw = '0;
    bus.exit_raw  = '0;
    bus.clr_err   = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.enter_raw = '0;
    bus.exit_raw  = '0;
    bus.clr_err   = 1'b0;
    bus.sel       = '0;
    do_reset();
    check("rst_rooms", 32'(bus.rooms), 32'h0);
    check("rst_total", 32'(bus.occ_total), 32'd0);
    check("rst_sel", 32'(bus.occ_sel), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    check("rst_udf", 32'(bus.udf), 32'h0);

    // Single entry on room 2: count appears exactly at edge 6.
    bus.enter_raw = 8'h04;
    tick(5);
    check("lat_edge5", 32'(bus.rooms), 32'h0);
    tick(1);
    check("lat_edge6", 32'(bus.rooms), 32'h04);
    tick(4);
    bus.sel = 3'd2;
    check("single_total", 32'(bus.occ_total), 32'd1);
    check("single_sel", 32'(bus.occ_sel), 32'd1);
    bus.enter_raw = '0;
    tick(8);
    check("single_once", 32'(bus.occ_total), 32'd1);

    // Debounce: 2-cycle glitch rejected, 1/0/1 bounce gives one event.
    do_reset();
    bus.enter_raw = 8'h01;
    tick(2);
    bus.enter_raw = 8'h00;
    tick(8);
    check("glitch_rooms", 32'(bus.rooms), 32'h0);
    bus.enter_raw = 8'h01; tick(1);
    bus.enter_raw = 8'h00; tick(1);
    bus.enter_raw = 8'h01; tick(8);
    bus.enter_raw = 8'h00; tick(8);
    bus.sel = 3'd0;
    check("bounce_sel", 32'(bus.occ_sel), 32'd1);
    check("bounce_total", 32'(bus.occ_total), 32'd1);

    // Room 5: 3 in, 1 out, 2 out, then an underflow.
    do_reset();
    bus.sel = 3'd5;
    repeat (3) ev(8'h20, 8'h00);
    ev(8'h00, 8'h20);
    check("r5_sel2", 32'(bus.occ_sel), 32'd2);
    check("r5_total2", 32'(bus.occ_total), 32'd2);
    check("r5_rooms", 32'(bus.rooms), 32'h20);
    repeat (2) ev(8'h00, 8'h20);
    check("r5_sel0", 32'(bus.occ_sel), 32'd0);
    check("r5_rooms0", 32'(bus.rooms), 32'h0);
    check("r5_udf0", 32'(bus.udf), 32'h0);
    ev(8'h00, 8'h20);
    check("r5_udf", 32'(bus.udf), 32'h20);
    check("r5_hold0", 32'(bus.occ_sel), 32'd0);

    // Room 7 saturation, clear, and set-wins-over-clear.
    do_reset();
    bus.sel = 3'd7;
    repeat (15) ev(8'h80, 8'h00);
    check("sat_15", 32'(bus.occ_sel), 32'd15);
    check("sat_no_ovf", 32'(bus.ovf), 32'h0);
    ev(8'h80, 8'h00);
    check("sat_hold", 32'(bus.occ_sel), 32'd15);
    check("sat_ovf", 32'(bus.ovf), 32'h80);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("clr_ovf", 32'(bus.ovf), 32'h0);
    bus.enter_raw = 8'h80;
    tick(5);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("set_wins", 32'(bus.ovf), 32'h80);
    bus.enter_raw = 8'h00;
    tick(6);
    check("sat_still15", 32'(bus.occ_sel), 32'd15);

    // Coincident enter/exit in room 1 leaves count and flags alone.
    do_reset();
    bus.sel = 3'd1;
    ev(8'h02, 8'h02);
    check("both_at0_cnt", 32'(bus.occ_sel), 32'd0);
    check("both_at0_udf", 32'(bus.udf), 32'h0);
    ev(8'h02, 8'h00);
    ev(8'h02, 8'h02);
    check("both_at1_cnt", 32'(bus.occ_sel), 32'd1);
    check("both_flags", 32'(bus.ovf | bus.udf), 32'h0);

    // All rooms at once, up to a full building total of 120.
    do_reset();
    ev(8'hFF, 8'h00);
    check("all_rooms", 32'(bus.rooms), 32'hFF);
    check("all_total8", 32'(bus.occ_total), 32'd8);
    repeat (14) ev(8'hFF, 8'h00);
    check("all_total120", 32'(bus.occ_total), 32'd120);
    check("all_no_ovf", 32'(bus.ovf), 32'h0);
    ev(8'hFF, 8'h00);
    check("all_ovf", 32'(bus.ovf), 32'hFF);
    check("all_total_hold", 32'(bus.occ_total), 32'd120);

    // Async reset mid-debounce clears outputs without a clock edge.
    bus.sel = 3'd3;
    bus.enter_raw = 8'hFF;
    tick(3);
    rst = 1'b1;
    #2;
    check("arst_rooms", 32'(bus.rooms), 32'h0);
    check("arst_total", 32'(bus.occ_total), 32'd0);
    check("arst_sel", 32'(bus.occ_sel), 32'd0);
    check("arst_flags", 32'(bus.ovf | bus.udf), 32'h0);
    bus.enter_raw = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("arst_after", 32'(bus.occ_total), 32'd0);
    ev(8'h01, 8'h00);
    check("arst_resume", 32'(bus.occ_total), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
